// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg: shared types and default geometry for the 3x3 window scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

    localparam int TAPS       = 9;
    localparam int DEF_IMG_W  = 30;
    localparam int DEF_IMG_H  = 18;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_PIX_W  = 9;

    typedef logic [3:0] tap_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/conv_window_sched_if.sv
// ----------------------------------------------------------------------------
// conv_window_sched_if: start/status, ROM port and tap stream of the scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface conv_window_sched_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
);

    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    tap_idx_t          tap_idx;
    logic              win_last;

    modport master (
        input  start, rom_data, pix_ready,
        output busy, done, rom_addr, pix_data, pix_valid, tap_idx, win_last
    );

    modport slave (
        output start, rom_data, pix_ready,
        input  busy, done, rom_addr, pix_data, pix_valid, tap_idx, win_last
    );

endinterface

`default_nettype wire

// File: rtl/conv_addr_gen.sv
// ----------------------------------------------------------------------------
// conv_addr_gen: 3x3 window/tap counters and incremental ROM address adder.
// Rev 1.0 -- zero-padding ("same") mode when CONV_WIN_PAD_EN is defined.
// ----------------------------------------------------------------------------
`default_nettype none

module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output tap_idx_t          tap_idx_o,
    output logic              last_tap_o
`ifdef CONV_WIN_PAD_EN
    ,
    output logic              pad_o
`endif
);

    localparam int DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW      = $clog2(DIM_MAX + 3);

`ifdef CONV_WIN_PAD_EN
    // Base tracks the top-left tap, one row and one column before the centre.
    localparam int COL_MAX = IMG_W - 1;
    localparam int ROW_MAX = IMG_H - 1;
    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(-(IMG_W + 1));
`else
    localparam int COL_MAX = IMG_W - 3;
    localparam int ROW_MAX = IMG_H - 3;
    localparam logic [ADDR_W-1:0] BASE0 = '0;
`endif

    localparam logic [CW-1:0]     COL_LAST     = CW'(COL_MAX);
    localparam logic [CW-1:0]     ROW_LAST     = CW'(ROW_MAX);
    localparam tap_idx_t          TAP_LAST     = tap_idx_t'(TAPS - 1);
    localparam logic [ADDR_W-1:0] TAP_ROW_INC  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] ROW_WRAP_INC = ADDR_W'(IMG_W - COL_MAX);

    logic [CW-1:0]     row_q, row_d, col_q, col_d;
    logic [1:0]        kx_q, kx_d, ky_q, ky_d;
    tap_idx_t          tap_q, tap_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic              last;

    assign last = (tap_q == TAP_LAST) && (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        kx_d   = kx_q;
        ky_d   = ky_q;
        tap_d  = tap_q;
        base_d = base_q;
        addr_d = addr_q;
        if (init_i) begin
            row_d  = '0;
            col_d  = '0;
            kx_d   = '0;
            ky_d   = '0;
            tap_d  = '0;
            base_d = BASE0;
            addr_d = BASE0;
        end else if (adv_i && !last) begin
            if (kx_q != 2'd2) begin
                kx_d   = kx_q + 2'd1;
                tap_d  = tap_q + 4'd1;
                addr_d = addr_q + 1'b1;
            end else if (ky_q != 2'd2) begin
                kx_d   = '0;
                ky_d   = ky_q + 2'd1;
                tap_d  = tap_q + 4'd1;
                addr_d = addr_q + TAP_ROW_INC;
            end else begin
                kx_d  = '0;
                ky_d  = '0;
                tap_d = '0;
                if (col_q != COL_LAST) begin
                    col_d  = col_q + 1'b1;
                    base_d = base_q + 1'b1;
                end else begin
                    col_d  = '0;
                    row_d  = row_q + 1'b1;
                    base_d = base_q + ROW_WRAP_INC;
                end
                addr_d = base_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q  <= '0;
            col_q  <= '0;
            kx_q   <= '0;
            ky_q   <= '0;
            tap_q  <= '0;
            base_q <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            tap_q  <= tap_d;
            base_q <= base_d;
            addr_q <= addr_d;
        end
    end

    assign tap_idx_o  = tap_q;
    assign last_tap_o = last;

`ifdef CONV_WIN_PAD_EN
    localparam logic [CW:0] RK_MAX = (CW + 1)'(IMG_H);
    localparam logic [CW:0] CK_MAX = (CW + 1)'(IMG_W);

    // Coordinates are offset by +1 so the padding ring sits at 0 and at size+1.
    function automatic logic f_outside(input logic [CW-1:0] r, input logic [CW-1:0] c,
                                       input logic [1:0] y, input logic [1:0] x);
        logic [CW:0] rk;
        logic [CW:0] ck;
        rk = {1'b0, r} + {{(CW - 1){1'b0}}, y};
        ck = {1'b0, c} + {{(CW - 1){1'b0}}, x};
        return (rk == '0) || (rk > RK_MAX) || (ck == '0) || (ck > CK_MAX);
    endfunction

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    assign rom_addr_d = f_outside(row_d, col_d, ky_d, kx_d) ? rom_addr_q : addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr_o = rom_addr_q;
    assign pad_o      = f_outside(row_q, col_q, ky_q, kx_q);
`else
    assign rom_addr_o = addr_q;
`endif

endmodule

`default_nettype wire

// File: rtl/conv_window_sched.sv
// ----------------------------------------------------------------------------
// conv_window_sched: walks a 3x3 window over the pixel ROM and streams taps.
// Rev 1.0 -- CONV_WIN_PAD_EN selects zero-padded "same" convolution.
// ----------------------------------------------------------------------------
`default_nettype none

module conv_window_sched
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic                clk,
    input  logic                reset,
    conv_window_sched_if.master bus
);

    state_t            state_q, state_d;
    logic              adv, init, step;
    logic [ADDR_W-1:0] rom_addr;
    tap_idx_t          tap_idx;
    logic              last_tap;

    logic [PIX_W-1:0]  pix_data_q;
    logic              pix_valid_q;
    tap_idx_t          tap_idx_q;
    logic              win_last_q;
    logic              done_q;

    assign adv  = !pix_valid_q || bus.pix_ready;
    assign init = (state_q == ST_IDLE) && bus.start;
    assign step = (state_q == ST_FETCH) && adv;

`ifdef CONV_WIN_PAD_EN
    logic pad;
`endif

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .init_i     (init),
        .adv_i      (step),
        .rom_addr_o (rom_addr),
        .tap_idx_o  (tap_idx),
        .last_tap_o (last_tap)
`ifdef CONV_WIN_PAD_EN
        ,
        .pad_o      (pad)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FLUSH lingers through the done cycle so busy drops as done does.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start)        state_d = ST_FETCH;
            ST_FETCH: if (adv && last_tap)  state_d = ST_FLUSH;
            ST_FLUSH: if (done_q)           state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            win_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == ST_FLUSH) && pix_valid_q && bus.pix_ready;
            if (step) begin
`ifdef CONV_WIN_PAD_EN
                pix_data_q <= pad ? '0 : bus.rom_data;
`else
                pix_data_q <= bus.rom_data;
`endif
                pix_valid_q <= 1'b1;
                tap_idx_q   <= tap_idx;
                win_last_q  <= last_tap;
            end else if (pix_valid_q && bus.pix_ready) begin
                pix_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.done      = done_q;
        bus.rom_addr  = rom_addr;
        bus.pix_data  = pix_data_q;
        bus.pix_valid = pix_valid_q;
        bus.tap_idx   = tap_idx_q;
        bus.win_last  = win_last_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_sched.sv
// ----------------------------------------------------------------------------
// tb_conv_window_sched: directed self-checking bench for conv_window_sched.
// Rev 1.0 -- expectations follow CONV_WIN_PAD_EN when it is defined.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_conv_window_sched;

    localparam int IMG_W  = 30;
    localparam int IMG_H  = 18;
    localparam int ADDR_W = 11;
    localparam int PIX_W  = 9;
    localparam int BUDGET = 30000;

`ifdef CONV_WIN_PAD_EN
    localparam int TOTAL     = 4860;
    localparam int WINS      = 540;
    localparam int LAST_BASE = 508;
    localparam int LAST_DATA = 0;
    int exp_first_data [9] = '{0, 0, 0, 0, 0, 1, 0, 30, 31};
`else
    localparam int TOTAL     = 4032;
    localparam int WINS      = 448;
    localparam int LAST_BASE = 477;
    localparam int LAST_DATA = 27;
    int exp_first_data [9] = '{0, 1, 2, 30, 31, 32, 60, 61, 62};
`endif
    int exp_first_addr [9] = '{0, 1, 2, 30, 31, 32, 60, 61, 62};

    logic clk;
    logic reset;

    conv_window_sched_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    assign bus.rom_data = bus.rom_addr[8:0];

    conv_window_sched #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W),
        .PIX_W  (PIX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int r_acc, r_win, r_done, r_bad, r_stall, r_range, r_first_valid;
    int first_addr [9];
    int first_data [9];
    int last_base, last_addr, last_data, last_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int k, output int ea, output int ed, output bit ep);
        int w, t, r, c;
        w = k / 9;
        t = k % 9;
`ifdef CONV_WIN_PAD_EN
        r  = w / IMG_W + t / 3 - 1;
        c  = w % IMG_W + t % 3 - 1;
        ep = (r < 0) || (r >= IMG_H) || (c < 0) || (c >= IMG_W);
`else
        r  = w / (IMG_W - 2) + t / 3;
        c  = w % (IMG_W - 2) + t % 3;
        ep = 1'b0;
`endif
        ea = r * IMG_W + c;
        ed = ep ? 0 : ea % 512;
    endfunction

    // Starts a frame at the current negedge and follows it tap by tap.
    task automatic run_frame(input int stall_pct, input int busy_start_at, input int stop_at);
        logic [ADDR_W-1:0] loads [$];
        logic [PIX_W-1:0]  h_data;
        logic [3:0]        h_tap;
        logic [ADDR_W-1:0] h_addr;
        logic [ADDR_W-1:0] la;
        bit held, pulsed, ep;
        int cyc, issued, ea, ed;
        held = 0; pulsed = 0; cyc = 0; issued = 0;
        h_data = '0; h_tap = '0; h_addr = '0;
        r_acc = 0; r_win = 0; r_done = 0; r_bad = 0; r_stall = 0; r_range = 0;
        r_first_valid = -1;
        bus.start     = 1'b1;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (r_acc < TOTAL && cyc < BUDGET) begin
            if (held && (bus.pix_valid !== 1'b1 || bus.pix_data !== h_data ||
                         bus.tap_idx !== h_tap || bus.rom_addr !== h_addr))
                r_stall++;
            if (bus.done === 1'b1) r_done++;
            if (bus.busy === 1'b1 && bus.rom_addr >= ADDR_W'(IMG_W * IMG_H)) r_range++;
            if (r_first_valid < 0 && bus.pix_valid === 1'b1) r_first_valid = cyc;
            bus.pix_ready = (int'($urandom_range(99)) >= stall_pct);
            bus.start = !pulsed && (busy_start_at >= 0) && (r_acc == busy_start_at);
            if (bus.start) pulsed = 1;
            if (bus.busy === 1'b1 && (bus.pix_valid !== 1'b1 || bus.pix_ready) && issued < TOTAL) begin
                loads.push_back(bus.rom_addr);
                issued++;
            end
            if (bus.pix_valid === 1'b1 && bus.pix_ready) begin
                model(r_acc, ea, ed, ep);
                la = (loads.size() > 0) ? loads.pop_front() : '1;
                if (r_acc < 9) begin
                    first_addr[r_acc] = int'(la);
                    first_data[r_acc] = int'(bus.pix_data);
                end
                if (r_acc == TOTAL - 9) last_base = int'(la);
                if (r_acc == TOTAL - 1) begin
                    last_addr = int'(la);
                    last_data = int'(bus.pix_data);
                    last_flag = int'(bus.win_last);
                end
                if (bus.pix_data !== PIX_W'(ed) || bus.tap_idx !== 4'(r_acc % 9) ||
                    bus.win_last !== (r_acc == TOTAL - 1) || (!ep && la !== ADDR_W'(ea)))
                    r_bad++;
                if (bus.tap_idx === 4'd8) r_win++;
                r_acc++;
            end
            held   = (bus.pix_valid === 1'b1) && !bus.pix_ready;
            h_data = bus.pix_data;
            h_tap  = bus.tap_idx;
            h_addr = bus.rom_addr;
            @(negedge clk);
            cyc++;
            if (stop_at >= 0 && r_acc >= stop_at) break;
        end
        bus.start     = 1'b0;
        bus.pix_ready = 1'b1;
    endtask

    task automatic end_frame(input string tag);
        chk({tag, "_taps"}, r_acc, TOTAL);
        chk({tag, "_stream"}, r_bad, 0);
        chk({tag, "_early_done"}, r_done, 0);
        chk({tag, "_done_pulse"}, bus.done, 1);
        chk({tag, "_busy_in_done"}, bus.busy, 1);
        chk({tag, "_valid_drop"}, bus.pix_valid, 0);
        @(negedge clk);
        chk({tag, "_done_width"}, bus.done, 0);
        chk({tag, "_busy_fall"}, bus.busy, 0);
    endtask

    initial begin
        int dn;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_pix_data", bus.pix_data, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_tap_idx", bus.tap_idx, 0);
        chk("rst_win_last", bus.win_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Frame A: no backpressure; first window and frame boundaries.
        run_frame(0, -1, -1);
        chk("a_first_valid_cycle", r_first_valid, 1);
        chk("a_windows", r_win, WINS);
        chk("a_addr_range", r_range, 0);
        for (int i = 0; i < 9; i++) begin
`ifndef CONV_WIN_PAD_EN
            chk($sformatf("a_first_addr%0d", i), first_addr[i], exp_first_addr[i]);
`endif
            chk($sformatf("a_first_data%0d", i), first_data[i], exp_first_data[i]);
        end
        chk("a_last_base", last_base, LAST_BASE);
        chk("a_last_addr", last_addr, 539);
        chk("a_last_data", last_data, LAST_DATA);
        chk("a_last_win_last", last_flag, 1);
        end_frame("a");

        // Frame B: ~40% of cycles stalled.
        run_frame(40, -1, -1);
        chk("b_stall_hold", r_stall, 0);
        chk("b_windows", r_win, WINS);
        chk("b_addr_range", r_range, 0);
        end_frame("b");

        // Frame C: start pulse mid-frame must be ignored.
        run_frame(0, 100, -1);
        end_frame("c");

        // Frame D starts the cycle after done, then is cut by an async reset.
        run_frame(0, -1, 2000);
        chk("d_taps_before_reset", r_acc, 2000);
        chk("d_stream", r_bad, 0);
`ifndef CONV_WIN_PAD_EN
        chk("d_start_addr", first_addr[0], 0);
`endif
        chk("d_busy_before_reset", bus.busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outputs",
            {bus.rom_addr, bus.pix_data, bus.pix_valid, bus.tap_idx, bus.win_last, bus.busy, bus.done},
            0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        chk("async_rst_no_done", dn, 0);
        chk("async_rst_idle", bus.busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_no_done", bus.done, 0);

        // Frame E: full pass after reset release.
        run_frame(0, -1, -1);
`ifndef CONV_WIN_PAD_EN
        chk("e_start_addr", first_addr[0], 0);
`endif
        chk("e_first_data4", first_data[4], exp_first_data[4]);
        end_frame("e");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
